// File: rtl/core_ex_issue.sv
// EX-stage issue unit: hands decoded ops to an execution unit, holds them until op_ready and buffers the result for MEM.
// Optional operand forwarding from the completing op / held result is enabled by defining CORE_EX_ISSUE_BYPASS_EN.
module core_ex_issue #(
  parameter int XLEN     = 32,
  parameter int OPW      = 5,
  parameter int RW       = 5,
  parameter int MAX_WAIT = 0
) (
  input  logic            clk,
  input  logic            rest,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [OPW-1:0]  id_op,
  input  logic [XLEN-1:0] id_in1,
  input  logic [XLEN-1:0] id_in2,
  input  logic [RW-1:0]   id_rd,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  output logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic            alu_op_wait_handle,
  input  logic            alu_op_ready,
  input  logic [XLEN-1:0] alu_out,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_result,
  output logic [RW-1:0]   mem_rd,
  output logic            timeout
);

  localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WCW-1:0] WLIM = WCW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t          state, state_next;
  logic [RW-1:0]   rd_q;
  logic [WCW-1:0]  wait_cnt;
  logic            complete;
  logic            accept;
  logic            abort;
  logic [XLEN-1:0] in1_sel;
  logic [XLEN-1:0] in2_sel;

`ifdef CORE_EX_ISSUE_BYPASS_EN
  // The completing op is newer than the held result, so it wins when both match.
  assign in1_sel = (id_rs1 != '0 && complete && id_rs1 == rd_q)     ? alu_out    :
                   (id_rs1 != '0 && mem_valid && id_rs1 == mem_rd)  ? mem_result : id_in1;
  assign in2_sel = (id_rs2 != '0 && complete && id_rs2 == rd_q)     ? alu_out    :
                   (id_rs2 != '0 && mem_valid && id_rs2 == mem_rd)  ? mem_result : id_in2;
`else
  logic unused_rs;
  assign unused_rs = ^{id_rs1, id_rs2};
  assign in1_sel   = id_in1;
  assign in2_sel   = id_in2;
`endif

  always_ff @(posedge clk or posedge rest) begin
    if (rest) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush)                 state_next = IDLE;
    else if (accept)           state_next = EXEC;
    else if (complete || abort) state_next = IDLE;
  end

  always_comb begin
    alu_op_wait_handle = (state == EXEC);
    complete = (state == EXEC) && alu_op_ready && (!mem_valid || mem_ready);
    id_ready = !rest && ((state == IDLE) || complete);
    accept   = id_valid && id_ready && !flush;
    abort    = (MAX_WAIT > 0) && (state == EXEC) && !complete && (wait_cnt == WLIM);
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      alu_op     <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      rd_q       <= '0;
      wait_cnt   <= '0;
      mem_valid  <= 1'b0;
      mem_result <= '0;
      mem_rd     <= '0;
      timeout    <= 1'b0;
    end else begin
      timeout <= !flush && abort;
      if (flush) begin
        mem_valid <= 1'b0;
        wait_cnt  <= '0;
      end else begin
        if (complete) begin
          mem_result <= alu_out;
          mem_rd     <= rd_q;
          mem_valid  <= 1'b1;
        end else if (mem_ready) begin
          mem_valid  <= 1'b0;
        end

        if (accept) begin
          alu_op   <= id_op;
          alu_in1  <= in1_sel;
          alu_in2  <= in2_sel;
          rd_q     <= id_rd;
          wait_cnt <= '0;
        end else if (abort) begin
          wait_cnt <= '0;
        end else if (state == EXEC && !complete) begin
          wait_cnt <= wait_cnt + WCW'(1);
        end
      end
    end
  end

endmodule
